ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (Hack RAM16K-style, 1-cycle read latency) between N_REQ requesters, e.g. CPU data port, screen refresh, keyboard DMA.
- Round-robin arbitration with valid/ready request handshake and optional lock for read-modify-write.
- Registered memory command stage; read responses are routed back to the originating requester.
- Sits between the requesters and the RAM macro in the Computer top level.

Parameters:
N_REQ, 3, number of requesters (2..8)
AW, 14, address width
DW, 16, data width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  request pending, one bit per requester
req_we  in  N_REQ  1 = write, 0 = read
req_lock  in  N_REQ  keep grant for this requester's next request
req_addr  in  N_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_wdata  in  N_REQ*DW  packed write data; requester i uses bits [i*DW +: DW]
req_ready  out  N_REQ  one-hot accept strobe, combinational
mem_en  out  1  registered command valid
mem_we  out  1  registered write enable
mem_addr  out  AW  registered address
mem_wdata  out  DW  registered write data
mem_rdata  in  DW  RAM read data, valid the cycle after mem_en && !mem_we
rsp_valid  out  N_REQ  one-hot read-data strobe, registered
rsp_data  out  DW  read data, shared by all requesters
busy_locked  out  1  a lock is currently held

Behaviour:
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, busy_locked=0. The rotating pointer is reset to 0 and the lock is cleared.
- Handshake: request i is accepted in cycle t when req_valid[i] && req_ready[i].
  - At most one req_ready bit is high per cycle.
  - req_ready never depends on itself and is 0 while reset=1.
  - Requesters hold valid, we, addr and wdata stable until accepted.
- Arbitration (state UNLOCKED):
  - Grant the first requester with valid=1, searching from ptr, ptr+1, ... modulo N_REQ.
  - On accept of i: ptr <= (i+1) mod N_REQ.
  - If req_lock[i]=1 on accept: go to LOCKED(owner=i) and assert busy_locked.
- State LOCKED(owner):
  - Only the owner can receive ready; all other requesters are stalled.
  - Each owner accept with lock=0 returns to UNLOCKED; ptr advances past the owner.
  - Owner idle (valid=0) keeps the lock indefinitely; no timeout.
- Command stage: on accept at cycle t, mem_en/mem_we/mem_addr/mem_wdata take the accepted values at edge t+1.
  - Without an accept, mem_en=0 and the other mem outputs hold their previous values.
  - Throughput is 1 transaction per cycle.
- Read return:
  - A read accepted at t drives mem_en at t+1; RAM data appears at t+2.
  - rsp_valid[i] and rsp_data are registered at edge t+3, i.e. 3 cycles of latency.
  - A 2-deep in-flight id pipeline (valid, we, id) tracks the routing.
  - Writes produce no rsp_valid.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
- Ordering: a write followed by a read to the same address, in consecutive accepts, returns the new data. This relies on RAM write-then-read ordering; the arbiter adds no forwarding.
- Reset mid-operation: in-flight reads are discarded; no rsp_valid is asserted after reset. The lock and ptr are cleared.
- Simultaneous events: lock release and another request in the same cycle means the other request waits one cycle, because arbitration uses the registered state.

Decomposition:
- Shared package ram_arb_pkg: typedef arb_state_t {UNLOCKED, LOCKED}, the command struct {we, addr, wdata}, and the id width function clog2(N_REQ).
- One sub-module rr_pick: combinational round-robin priority picker with inputs (req vector, ptr) and a one-hot output. It is reused later for the I/O bus arbiter.

Test Plan:
- Single read, N_REQ=3, RAM preloaded with mem[0x0010]=0xBEEF: req 1 reads 0x0010 at t0 -> req_ready=3'b010 at t0, mem_en=1 with addr 0x0010 at t1, rsp_valid=3'b010 with rsp_data=0xBEEF at t3.
- Fairness: all 3 requesters hold valid for 6 cycles after reset -> accept order 0,1,2,0,1,2 and no starvation.
- Lock: req 2 reads 0x0100 with lock=1, then writes 0x0100=0x1234 with lock=0, while req 0 and req 1 stay valid.
  - Required: req 0/1 get no ready until the write is accepted and busy_locked is 1 in between.
  - Next grant goes to 0.
- Write then read: req 0 writes 0x2000=0xA5A5, then reads 0x2000 in the next cycle -> rsp_data=0xA5A5 with rsp_valid=3'b001, and no response for the write.
- Pipelined reads: req 0 and req 1 read 0x0001 and 0x0002 back-to-back (contents 0x0011, 0x0022) -> consecutive rsp_valid 001 then 010 with the matching data.
- Reset mid-flight: assert reset 1 cycle after accepting a read -> no rsp_valid ever for it, all outputs 0 during reset, and the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: arbitration state, memory command, id width helper.
// Types only, no logic; the command widths match the Hack RAM16K macro.
package ram_arb_pkg;

    localparam int RAM_AW = 14;
    localparam int RAM_DW = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } cmd_t;

    // Requester id width; never below 1 so a 2-requester build still has a real field.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester, RAM-command and response bundle of the RAM port arbiter; master is the
// requester/RAM side, slave is the arbiter. No logic, no added latency.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = RAM_AW,
    parameter int DW    = RAM_DW
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ-1:0]    req_lock;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    req_ready;
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                busy_locked;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, busy_locked
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, busy_locked
    );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin priority picker: one-hot grant of the first set req bit at or after ptr.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest requester is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with RMW lock sharing one 1-cycle-latency RAM; command registered
// 1 cycle after accept, read data returned 3 cycles after accept. Stalls via req_ready.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = RAM_AW,
    parameter int DW    = RAM_DW
) (
    input  logic               clk,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    localparam int IW = clog2(N_REQ);

    arb_state_t       state, state_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] ready;
    logic             accept;
    logic [IW-1:0]    acc_id;
    cmd_t             acc_cmd;
    cmd_t             mem_cmd;
    logic             mem_en_q;
    logic [1:0]       pipe_vld;
    logic [1:0]       pipe_we;
    logic [IW-1:0]    pipe_id0, pipe_id1;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [DW-1:0]    rsp_data_q;

    rr_pick #(.N(N_REQ), .PW(IW)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (pick)
    );

    // Grant comes from registered state only, so a lock release cannot hand over in the same cycle.
    always_comb begin
        ready = '0;
        if (!reset) begin
            if (state == LOCKED) ready[owner] = bus.req_valid[owner];
            else                 ready = pick;
        end
    end

    assign accept = |ready;

    always_comb begin
        acc_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ready[i]) acc_id = IW'(i);
        end
    end

    always_comb begin
        acc_cmd.we    = bus.req_we[acc_id];
        acc_cmd.addr  = bus.req_addr[acc_id*AW +: AW];
        acc_cmd.wdata = bus.req_wdata[acc_id*DW +: DW];
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        if (accept) begin
            ptr_n   = (acc_id == IW'(N_REQ - 1)) ? '0 : acc_id + 1'b1;
            owner_n = acc_id;
            state_n = bus.req_lock[acc_id] ? LOCKED : UNLOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNLOCKED;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_q <= 1'b0;
            mem_cmd  <= '0;
        end else begin
            mem_en_q <= accept;
            if (accept) mem_cmd <= acc_cmd;
        end
    end

    // Stage 0 lines up with the registered command, stage 1 with RAM data on mem_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld    <= '0;
            pipe_we     <= '0;
            pipe_id0    <= '0;
            pipe_id1    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            pipe_vld    <= {pipe_vld[0], accept};
            pipe_we     <= {pipe_we[0], acc_cmd.we};
            pipe_id0    <= acc_id;
            pipe_id1    <= pipe_id0;
            rsp_valid_q <= '0;
            if (pipe_vld[1] && !pipe_we[1]) begin
                rsp_valid_q[pipe_id1] <= 1'b1;
                rsp_data_q            <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_cmd.we;
    assign bus.mem_addr    = mem_cmd.addr;
    assign bus.mem_wdata   = mem_cmd.wdata;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy_locked = (state == LOCKED);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM16K, read-response scoreboard fed at accept time,
// and one task per scenario with inline expectations.
module tb_ram_port_arbiter;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    ram_port_arbiter_if #(.N_REQ(3), .AW(14), .DW(16)) bus ();

    ram_port_arbiter #(.N_REQ(3), .AW(14), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  oh;
        logic [15:0] data;
    } exp_t;

    logic [15:0] ram [0:16383];
    logic [15:0] shadow [logic [13:0]];
    exp_t        exp_q [$];
    int          acc_log [$];
    logic [13:0] mon_addr;
    exp_t        mon_e;

    function automatic logic [15:0] init_val(input logic [13:0] a);
        case (a)
            14'h0010: return 16'hBEEF;
            14'h0001: return 16'h0011;
            14'h0002: return 16'h0022;
            default:  return {2'b10, a} ^ 16'h3C3C;
        endcase
    endfunction

    function automatic logic [15:0] exp_val(input logic [13:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // Scoreboard: reads push their expected data at accept time, responses pop in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    acc_log.push_back(i);
                    mon_addr = bus.req_addr[i*14 +: 14];
                    if (bus.req_we[i]) shadow[mon_addr] = bus.req_wdata[i*16 +: 16];
                    else exp_q.push_back({3'(1 << i), exp_val(mon_addr)});
                end
            end
            n_chk++;
            if ($countones(bus.req_ready) > 1)
                $display("FAIL ready_onehot: got %b required at most one bit", bus.req_ready);
            else n_pass++;
        end
        if (bus.rsp_valid != 3'b000) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got valid %b data %h required no response",
                         bus.rsp_valid, bus.rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rsp_valid !== mon_e.oh || bus.rsp_data !== mon_e.data)
                    $display("FAIL rsp_scoreboard: got %b/%h required %b/%h",
                             bus.rsp_valid, bus.rsp_data, mon_e.oh, mon_e.data);
                else n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lock,
                           input logic [13:0] addr, input logic [15:0] wd);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_lock[i]           = lock;
        bus.req_addr[i*14 +: 14]  = addr;
        bus.req_wdata[i*16 +: 16] = wd;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, 14'(8'h30 + i), 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b000)
            $display("FAIL reset_ready: got %b required 000", bus.req_ready);
        else n_pass++;
        n_chk++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 32'h0)
            $display("FAIL reset_mem: got en %b we %b addr %h wdata %h required all 0",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        n_chk++;
        if ({bus.rsp_valid, bus.rsp_data, bus.busy_locked} !== 20'h0)
            $display("FAIL reset_rsp: got valid %b data %h busy %b required all 0",
                     bus.rsp_valid, bus.rsp_data, bus.busy_locked);
        else n_pass++;
        step();
        reset = 1'b0;
        idle_all();
    endtask

    task automatic test_single_read();
        int lat;
        logic [2:0]  got_v;
        logic [15:0] got_d;
        lat   = 0;
        got_v = '0;
        got_d = '0;
        step();
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h0010, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b010) $display("FAIL single_ready: got %b required 010", bus.req_ready);
        else n_pass++;
        step();
        idle_all();
        @(negedge clk);
        n_chk++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0010)
            $display("FAIL single_cmd: got en %b we %b addr %h required 1 0 0010",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        else n_pass++;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 3'b000 && lat == 0) begin
                lat   = k;
                got_v = bus.rsp_valid;
                got_d = bus.rsp_data;
            end
        end
        n_chk++;
        if (lat != 3 || got_v !== 3'b010 || got_d !== 16'hBEEF)
            $display("FAIL single_rsp: got latency %0d valid %b data %h required 3 010 beef",
                     lat, got_v, got_d);
        else n_pass++;
    endtask

    task automatic test_fairness();
        do_reset();
        acc_log.delete();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, 14'(8'h40 + i), 16'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.req_ready !== 3'(1 << (k % 3)))
                $display("FAIL fair_grant_%0d: got %b required %b", k, bus.req_ready, 3'(1 << (k % 3)));
            else n_pass++;
            step();
        end
        idle_all();
        n_chk++;
        if (acc_log.size() != 6 || acc_log[0] != 0 || acc_log[1] != 1 || acc_log[2] != 2 ||
            acc_log[3] != 0 || acc_log[4] != 1 || acc_log[5] != 2)
            $display("FAIL fair_order: got %0d accepts required order 0,1,2,0,1,2", acc_log.size());
        else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lock();
        step();
        set_req(2, 1'b1, 1'b0, 1'b1, 14'h0100, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b100) $display("FAIL lock_acquire: got %b required 100", bus.req_ready);
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            step();
            set_req(2, 1'b0, 1'b0, 1'b0, 14'h0100, 16'h0);
            set_req(0, 1'b1, 1'b0, 1'b0, 14'h0050, 16'h0);
            set_req(1, 1'b1, 1'b0, 1'b0, 14'h0051, 16'h0);
            @(negedge clk);
            n_chk++;
            if (bus.req_ready !== 3'b000 || bus.busy_locked !== 1'b1)
                $display("FAIL lock_stall_%0d: got ready %b busy %b required 000 1",
                         c, bus.req_ready, bus.busy_locked);
            else n_pass++;
        end
        step();
        set_req(2, 1'b1, 1'b1, 1'b0, 14'h0100, 16'h1234);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b100 || bus.busy_locked !== 1'b1)
            $display("FAIL lock_release: got ready %b busy %b required 100 1", bus.req_ready, bus.busy_locked);
        else n_pass++;
        step();
        set_req(2, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b001 || bus.busy_locked !== 1'b0)
            $display("FAIL lock_next: got ready %b busy %b required 001 0", bus.req_ready, bus.busy_locked);
        else n_pass++;
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b010) $display("FAIL lock_after: got %b required 010", bus.req_ready);
        else n_pass++;
        step();
        idle_all();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write_then_read();
        int          n_rsp;
        logic [2:0]  got_v;
        logic [15:0] got_d;
        n_rsp = 0;
        got_v = '0;
        got_d = '0;
        step();
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h2000, 16'hA5A5);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b001) $display("FAIL wr_ready: got %b required 001", bus.req_ready);
        else n_pass++;
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h2000, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b001) $display("FAIL rd_ready: got %b required 001", bus.req_ready);
        else n_pass++;
        step();
        idle_all();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 3'b000) begin
                n_rsp++;
                got_v = bus.rsp_valid;
                got_d = bus.rsp_data;
            end
        end
        n_chk++;
        if (n_rsp != 1 || got_v !== 3'b001 || got_d !== 16'hA5A5)
            $display("FAIL wr_then_rd: got %0d responses valid %b data %h required 1 001 a5a5",
                     n_rsp, got_v, got_d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  rv [8];
        logic [15:0] rd [8];
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h0001, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b001) $display("FAIL b2b_ready0: got %b required 001", bus.req_ready);
        else n_pass++;
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h0002, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b010) $display("FAIL b2b_ready1: got %b required 010", bus.req_ready);
        else n_pass++;
        step();
        idle_all();
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            rv[k] = bus.rsp_valid;
            rd[k] = bus.rsp_data;
        end
        n_chk++;
        if (rv[3] !== 3'b001 || rd[3] !== 16'h0011)
            $display("FAIL b2b_first: got %b/%h required 001/0011", rv[3], rd[3]);
        else n_pass++;
        n_chk++;
        if (rv[4] !== 3'b010 || rd[4] !== 16'h0022)
            $display("FAIL b2b_second: got %b/%h required 010/0022", rv[4], rd[4]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        step();
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h0010, 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b010) $display("FAIL mid_accept: got %b required 010", bus.req_ready);
        else n_pass++;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, 14'(8'h60 + i), 16'h0);
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b000) $display("FAIL mid_ready_in_reset: got %b required 000", bus.req_ready);
        else n_pass++;
        step();
        @(negedge clk);
        n_chk++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rsp_valid, bus.rsp_data,
             bus.busy_locked, bus.req_ready} !== 55'h0)
            $display("FAIL mid_outputs: got en %b addr %h valid %b data %h busy %b ready %b required all 0",
                     bus.mem_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy_locked, bus.req_ready);
        else n_pass++;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.req_ready !== 3'b001 || bus.rsp_valid !== 3'b000)
            $display("FAIL mid_first_grant: got ready %b rsp %b required 001 000", bus.req_ready, bus.rsp_valid);
        else n_pass++;
        step();
        idle_all();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[1]) stale++;
        end
        n_chk++;
        if (stale != 0) $display("FAIL mid_stale_rsp: got %0d responses to req 1 required 0", stale);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        idle_all();
        for (int a = 0; a < 16384; a++) ram[a] = init_val(14'(a));
        test_reset();
        test_single_read();
        test_fairness();
        test_lock();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drained: got %0d pending required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
